timer_controller: RTL and testbench
===================================

Name: timer_controller

Overview:
Countdown-timer sequencer that owns the HH:MM:SS time registers feeding the 7-segment decoder's seconds_in/minutes_in/hours_in inputs. It runs a user-facing FSM (set, run, pause, expire) from single-cycle button pulses. It derives a 1 Hz decrement tick from the system clock. Outputs are always in range (hours < 24, minutes/seconds < 60), so the decoder never hits its out-of-range fallback.

Parameters:
TICKS_PER_SEC, 50_000_000, clock cycles per second tick; must be >= 4.

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
btn_start_stop  input  1  single-cycle pulse, pre-debounced
btn_clear  input  1  single-cycle pulse, pre-debounced
btn_set  input  1  single-cycle pulse; steps set-field selection
btn_inc  input  1  single-cycle pulse; increments selected field
seconds_out  output  32  registered seconds 0..59, zero-extended
minutes_out  output  32  registered minutes 0..59, zero-extended
hours_out  output  32  registered hours 0..23, zero-extended
state_out  output  3  current FSM state encoding
running  output  1  high while in RUN
alarm  output  1  high while in DONE
done_pulse  output  1  one-cycle pulse on entry to DONE
blank_digits  output  6  per-digit blank mask; bit 5 = hour tens ... bit 0 = second units

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset: state IDLE; time regs 00:00:00; prescaler 0; running, alarm, done_pulse 0; blank_digits 0.
- States: IDLE=0, SET_HH=1, SET_MM=2, SET_SS=3, RUN=4, PAUSE=5, DONE=6.
- Button priority within a cycle: clear > start_stop > set > inc. Lower-priority pulses in the same cycle are dropped.
- clear, in any state: time := 0, prescaler := 0, next state IDLE.
- IDLE:
  - start_stop with time != 0 -> RUN, prescaler := 0.
  - start_stop with time == 0 -> stay in IDLE.
  - set -> SET_HH.
  - inc ignored.
- SET_HH / SET_MM / SET_SS:
  - inc increments the selected field: hours wrap 23->0; minutes and seconds wrap 59->0. No carry into other fields.
  - set advances SET_HH->SET_MM->SET_SS->IDLE.
  - start_stop ignored.
- RUN:
  - Prescaler counts 0..TICKS_PER_SEC-1; sec_tick fires on the cycle the count equals TICKS_PER_SEC-1, then the count wraps to 0.
  - On sec_tick, decrement with borrow: ss>0 -> ss-1. Otherwise ss:=59 and borrow from mm; mm borrows from hh the same way.
  - If the pre-tick value is 00:00:01: time becomes 0, next state DONE. done_pulse is high in the first DONE cycle only.
  - start_stop -> PAUSE; prescaler value is held.
  - Same cycle start_stop + sec_tick: the decrement is applied, then PAUSE. If that decrement reaches zero, DONE wins.
  - set and inc ignored.
- PAUSE:
  - Time and prescaler frozen.
  - start_stop -> RUN, resuming the prescaler from its held value.
  - set and inc ignored.
- DONE:
  - alarm = 1, time stays 0.
  - start_stop or clear -> IDLE.
- Latency: outputs are registered. A button pulse in cycle N is visible on the outputs in cycle N+1.

Optional Feature:
Macro TIMER_BLINK_EN.
- Defined: in SET_* states, a blink counter toggles a phase bit every TICKS_PER_SEC/4 clocks.
  - Phase 1 blanks the selected field's two digits: SET_HH = 6'b110000, SET_MM = 6'b001100, SET_SS = 6'b000011.
  - The counter resets to phase 0 (visible) on entering any SET_* state and on each inc pulse.
  - blank_digits = 0 in all other states.
- Undefined: no blink counter; blank_digits tied to 0.

Decomposition:
- Package timer_pkg: state encodings, MAX_SEC=59, MAX_MIN=59, MAX_HOUR=23, field width constants, blank masks per field.
- One sub-module, sec_prescaler: TICKS_PER_SEC counter with enable, synchronous clear, and one-cycle tick output. Used for the 1 Hz tick; reused (with divisor TICKS_PER_SEC/4) for the blink counter when TIMER_BLINK_EN is defined.

Test Plan (TICKS_PER_SEC=4):
1. Reset -> outputs 0, state_out=0. Then set, inc x3, set, inc x2, set, inc x5, set -> IDLE with 03:02:05.
2. Load 00:01:00, start_stop -> after 4 clocks 00:00:59; after 240 clocks from start, state DONE, done_pulse for exactly 1 cycle, alarm held high.
3. Load 01:00:00 and run one tick -> 00:59:59. Separately: SET_HH, inc x24 -> hours back to 0. SET_SS, inc x60 -> seconds back to 0.
4. RUN, start_stop at prescaler=2 -> PAUSE, time frozen for 20 clocks; start_stop -> next tick 2 clocks later.
5. Same-cycle clear+start_stop in RUN -> IDLE, time 0. Start_stop at 00:00:00 in IDLE -> stays IDLE. Reset asserted mid-RUN -> all outputs 0 next cycle.
6. With TIMER_BLINK_EN: in SET_MM, blank_digits alternates 000000/001100 every 1 clock period of the blink divisor; inc forces 000000. Without the macro, blank_digits stays 0.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: state encodings, field limits and per-field blank masks for timer_controller.
package timer_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SET_HH = 3'd1,
    SET_MM = 3'd2,
    SET_SS = 3'd3,
    RUN    = 3'd4,
    PAUSE  = 3'd5,
    DONE   = 3'd6
  } state_t;
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;
  localparam logic [SEC_W-1:0]  MAX_SEC  = 6'd59;
  localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;
  localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
  localparam logic [5:0] BLANK_HH = 6'b110000;
  localparam logic [5:0] BLANK_MM = 6'b001100;
  localparam logic [5:0] BLANK_SS = 6'b000011;
  function automatic logic is_set(input state_t s);
    return s == SET_HH || s == SET_MM || s == SET_SS;
  endfunction
  function automatic logic [5:0] blank_mask(input state_t s);
    return s == SET_HH ? BLANK_HH : s == SET_MM ? BLANK_MM : s == SET_SS ? BLANK_SS : 6'b0;
  endfunction
endpackage

// File: rtl/timer_controller_sec_prescaler.sv
// sec_prescaler: modulo-DIV counter with enable, hold, sync clear and a one-cycle tick at DIV-1.
module sec_prescaler #(
  parameter int DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic hold,
  input  logic clr,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  logic at_max;
  assign at_max = cnt_q == W'(DIV - 1);
  assign tick = en && !clr && at_max;
  // hold freezes the count, but a tick in the same cycle still wraps it
  always_comb begin
    cnt_d = cnt_q;
    if (clr) cnt_d = '0;
    else if (en && (!hold || at_max)) cnt_d = at_max ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/timer_controller.sv
// timer_controller: HH:MM:SS countdown sequencer with set/run/pause/done FSM.
// Define TIMER_BLINK_EN to blink the selected field while setting.
module timer_controller
  import timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_start_stop,
  input  logic        btn_clear,
  input  logic        btn_set,
  input  logic        btn_inc,
  output logic [31:0] seconds_out,
  output logic [31:0] minutes_out,
  output logic [31:0] hours_out,
  output logic [2:0]  state_out,
  output logic        running,
  output logic        alarm,
  output logic        done_pulse,
  output logic [5:0]  blank_digits
);
  state_t state_q, state_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic [MIN_W-1:0] min_q, min_d;
  logic [HOUR_W-1:0] hour_q, hour_d;
  logic done_q, done_d;
  logic clr_b, ss_b, set_b, inc_b;
  logic sec_tick, time_zero, time_one;
  assign clr_b = btn_clear;
  assign ss_b  = btn_start_stop && !btn_clear;
  assign set_b = btn_set && !btn_start_stop && !btn_clear;
  assign inc_b = btn_inc && !btn_set && !btn_start_stop && !btn_clear;
  assign time_zero = hour_q == '0 && min_q == '0 && sec_q == '0;
  assign time_one  = hour_q == '0 && min_q == '0 && sec_q == SEC_W'(1);
  sec_prescaler #(.DIV(TICKS_PER_SEC)) u_sec (
    .clock (clock),
    .reset (reset),
    .en    (state_q == RUN),
    .hold  (ss_b),
    .clr   (clr_b || !(state_q == RUN || state_q == PAUSE)),
    .tick  (sec_tick)
  );
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    if (clr_b) begin
      state_d = IDLE;
      sec_d   = '0;
      min_d   = '0;
      hour_d  = '0;
    end else begin
      case (state_q)
        IDLE:    state_d = ss_b ? (time_zero ? IDLE : RUN) : set_b ? SET_HH : IDLE;
        SET_HH: begin
          state_d = set_b ? SET_MM : SET_HH;
          if (inc_b) hour_d = hour_q == MAX_HOUR ? '0 : hour_q + 1'b1;
        end
        SET_MM: begin
          state_d = set_b ? SET_SS : SET_MM;
          if (inc_b) min_d = min_q == MAX_MIN ? '0 : min_q + 1'b1;
        end
        SET_SS: begin
          state_d = set_b ? IDLE : SET_SS;
          if (inc_b) sec_d = sec_q == MAX_SEC ? '0 : sec_q + 1'b1;
        end
        RUN: begin
          if (sec_tick) begin
            sec_d  = sec_q != '0 ? sec_q - 1'b1 : MAX_SEC;
            min_d  = sec_q != '0 ? min_q : min_q != '0 ? min_q - 1'b1 : MAX_MIN;
            hour_d = sec_q == '0 && min_q == '0 ? hour_q - 1'b1 : hour_q;
          end
          state_d = sec_tick && time_one ? DONE : ss_b ? PAUSE : RUN;
        end
        PAUSE:   state_d = ss_b ? RUN : PAUSE;
        DONE:    state_d = ss_b ? IDLE : DONE;
        default: state_d = IDLE;
      endcase
    end
    done_d = state_d == DONE && state_q != DONE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      done_q  <= done_d;
    end
  end
`ifdef TIMER_BLINK_EN
  logic phase_q, phase_d, blink_tick, blink_clr;
  logic [5:0] blank_q, blank_d;
  // restart the blink cycle visible whenever a field is entered or edited
  assign blink_clr = (is_set(state_d) && state_d != state_q) || inc_b;
  sec_prescaler #(.DIV(TICKS_PER_SEC / 4)) u_blink (
    .clock (clock),
    .reset (reset),
    .en    (is_set(state_q)),
    .hold  (1'b0),
    .clr   (blink_clr),
    .tick  (blink_tick)
  );
  always_comb begin
    phase_d = is_set(state_d) && !blink_clr && (phase_q ^ blink_tick);
    blank_d = phase_d ? blank_mask(state_d) : 6'b0;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q <= 1'b0;
      blank_q <= '0;
    end else begin
      phase_q <= phase_d;
      blank_q <= blank_d;
    end
  end
  assign blank_digits = blank_q;
`else
  assign blank_digits = '0;
`endif
  assign seconds_out = {{(32 - SEC_W){1'b0}}, sec_q};
  assign minutes_out = {{(32 - MIN_W){1'b0}}, min_q};
  assign hours_out   = {{(32 - HOUR_W){1'b0}}, hour_q};
  assign state_out   = state_q;
  assign running     = state_q == RUN;
  assign alarm       = state_q == DONE;
  assign done_pulse  = done_q;
endmodule

// File: tb/tb_timer_controller.sv
// tb_timer_controller: table vectors, directed corner sequences and random buttons vs a total-seconds model.
module tb_timer_controller;
  localparam int T = 4;
  logic clock = 1'b0, reset = 1'b1;
  logic b_ss = 1'b0, b_cl = 1'b0, b_set = 1'b0, b_inc = 1'b0;
  logic [31:0] sec_o, min_o, hr_o;
  logic [2:0] st_o;
  logic run_o, alarm_o, done_o;
  logic [5:0] blank_o;
  always #5 clock = ~clock;
  timer_controller #(.TICKS_PER_SEC(T)) dut (
    .clock(clock), .reset(reset), .btn_start_stop(b_ss), .btn_clear(b_cl), .btn_set(b_set),
    .btn_inc(b_inc), .seconds_out(sec_o), .minutes_out(min_o), .hours_out(hr_o), .state_out(st_o),
    .running(run_o), .alarm(alarm_o), .done_pulse(done_o), .blank_digits(blank_o)
  );
  int checks = 0, failures = 0;
  int m_t, m_st, m_pre, m_bc;
  bit m_done, m_ph;
  task automatic chk(input string nm, input logic [107:0] act, input logic [107:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [107:0] exp_vec();
    logic [5:0] bl;
    bl = !m_ph ? 6'b0 : m_st == 1 ? 6'b110000 : m_st == 2 ? 6'b001100 : m_st == 3 ? 6'b000011 : 6'b0;
    return {32'(m_t / 3600), 32'((m_t / 60) % 60), 32'(m_t % 60), 3'(m_st),
            m_st == 4, m_st == 6, m_done, bl};
  endfunction
  function automatic logic [107:0] act_vec();
    return {hr_o, min_o, sec_o, st_o, run_o, alarm_o, done_o, blank_o};
  endfunction
  task automatic model_step(input bit ss, cl, st, inc);
    int ost = m_st;
    int h = m_t / 3600, m = (m_t / 60) % 60, s = m_t % 60;
    bit tick;
    bit inc_eff = inc && !cl && !ss && !st;
    if (cl) begin
      m_t = 0; m_st = 0; m_pre = 0;
    end else case (m_st)
      0: if (ss) begin if (m_t != 0) begin m_st = 4; m_pre = 0; end end else if (st) m_st = 1;
      1, 2, 3: if (!ss) begin
        if (st) m_st = m_st == 3 ? 0 : m_st + 1;
        else if (inc) begin
          if (m_st == 1) h = (h + 1) % 24;
          if (m_st == 2) m = (m + 1) % 60;
          if (m_st == 3) s = (s + 1) % 60;
          m_t = h * 3600 + m * 60 + s;
        end
      end
      4: begin
        tick = m_pre == T - 1;
        if (tick) begin m_t--; m_pre = 0; end
        else if (!ss) m_pre++;
        if (tick && m_t == 0) m_st = 6;
        else if (ss) m_st = 5;
      end
      5: if (ss) m_st = 4;
      6: if (ss) m_st = 0;
      default: m_st = 0;
    endcase
    m_done = m_st == 6 && ost != 6;
`ifdef TIMER_BLINK_EN
    if (m_st >= 1 && m_st <= 3) begin
      if (m_st != ost || inc_eff) begin m_bc = 0; m_ph = 0; end
      else begin m_bc++; if (m_bc == T / 4) begin m_bc = 0; m_ph = !m_ph; end end
    end else begin m_bc = 0; m_ph = 0; end
`else
    if (inc_eff) m_bc = 0;
`endif
  endtask
  task automatic cycle(input bit ss, cl, st, inc, input string nm = "cyc");
    b_ss = ss; b_cl = cl; b_set = st; b_inc = inc;
    model_step(ss, cl, st, inc);
    @(posedge clock); #1;
    b_ss = 0; b_cl = 0; b_set = 0; b_inc = 0;
    chk(nm, act_vec(), exp_vec());
  endtask
  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 0, 0, "idle");
  endtask
  task automatic do_reset();
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    m_t = 0; m_st = 0; m_pre = 0; m_bc = 0; m_done = 0; m_ph = 0;
    chk("reset", act_vec(), exp_vec());
    chk("reset_zero", act_vec(), 108'd0);
  endtask
  task automatic load(input int h, m, s);
    cycle(0, 1, 0, 0, "load");
    cycle(0, 0, 1, 0, "load");
    repeat (h) cycle(0, 0, 0, 1, "load");
    cycle(0, 0, 1, 0, "load");
    repeat (m) cycle(0, 0, 0, 1, "load");
    cycle(0, 0, 1, 0, "load");
    repeat (s) cycle(0, 0, 0, 1, "load");
    cycle(0, 0, 1, 0, "load");
  endtask
  typedef struct { bit ss, cl, st, inc; int h, m, s, state; } vec_t;
  vec_t tbl[17];
  initial begin
    tbl = '{
      '{0,0,1,0, 0,0,0,1}, '{0,0,0,1, 1,0,0,1}, '{0,0,0,1, 2,0,0,1}, '{0,0,0,1, 3,0,0,1},
      '{0,0,1,0, 3,0,0,2}, '{0,0,0,1, 3,1,0,2}, '{0,0,0,1, 3,2,0,2}, '{0,0,1,0, 3,2,0,3},
      '{0,0,0,1, 3,2,1,3}, '{0,0,0,1, 3,2,2,3}, '{0,0,0,1, 3,2,3,3}, '{0,0,0,1, 3,2,4,3},
      '{0,0,0,1, 3,2,5,3}, '{0,0,1,0, 3,2,5,0}, '{0,0,1,1, 3,2,5,1}, '{1,0,0,1, 3,2,5,1},
      '{0,1,1,0, 0,0,0,0}
    };
    do_reset();
    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].ss, tbl[i].cl, tbl[i].st, tbl[i].inc, $sformatf("tbl%0d_model", i));
      chk($sformatf("tbl%0d", i), {hr_o, min_o, sec_o, 12'(st_o)},
          {32'(tbl[i].h), 32'(tbl[i].m), 32'(tbl[i].s), 12'(tbl[i].state)});
    end
    load(0, 1, 0);
    cycle(1, 0, 0, 0, "t2_start");
    idle(4);
    chk("t2_first_tick", {min_o, sec_o}, {32'd0, 32'd59});
    idle(235);
    chk("t2_before_done", {sec_o, 29'(st_o)}, {32'd1, 29'd4});
    idle(1);
    chk("t2_done", {sec_o, st_o, alarm_o, done_o}, {32'd0, 3'd6, 1'b1, 1'b1});
    idle(1);
    chk("t2_done_pulse_once", {st_o, alarm_o, done_o}, {3'd6, 1'b1, 1'b0});
    cycle(1, 0, 0, 0, "t2_exit");
    chk("t2_idle", 108'(st_o), 108'd0);
    load(1, 0, 0);
    cycle(1, 0, 0, 0, "t3_start");
    idle(4);
    chk("t3_borrow", {hr_o, min_o, sec_o}, {32'd0, 32'd59, 32'd59});
    cycle(0, 1, 0, 0, "t3_clear");
    cycle(0, 0, 1, 0, "t3_sethh");
    repeat (23) cycle(0, 0, 0, 1, "t3_inc_h");
    chk("t3_hour23", 108'(hr_o), 108'd23);
    cycle(0, 0, 0, 1, "t3_wrap_h");
    chk("t3_hour_wrap", 108'(hr_o), 108'd0);
    cycle(0, 0, 1, 0, "t3_setmm");
    cycle(0, 0, 1, 0, "t3_setss");
    repeat (60) cycle(0, 0, 0, 1, "t3_inc_s");
    chk("t3_sec_wrap", {min_o, sec_o, 29'(st_o)}, {32'd0, 32'd0, 29'd3});
    load(0, 0, 10);
    cycle(1, 0, 0, 0, "t4_start");
    idle(2);
    cycle(1, 0, 0, 0, "t4_pause");
    chk("t4_paused", {sec_o, 29'(st_o)}, {32'd10, 29'd5});
    idle(20);
    chk("t4_frozen", {sec_o, 29'(st_o)}, {32'd10, 29'd5});
    cycle(1, 0, 0, 0, "t4_resume");
    idle(1);
    chk("t4_no_tick_yet", 108'(sec_o), 108'd10);
    idle(1);
    chk("t4_tick", 108'(sec_o), 108'd9);
    cycle(1, 1, 0, 0, "t5_clear_ss");
    chk("t5_cleared", {sec_o, 29'(st_o)}, {32'd0, 29'd0});
    cycle(1, 0, 0, 0, "t5_ss_zero");
    chk("t5_stay_idle", 108'(st_o), 108'd0);
    load(0, 0, 5);
    cycle(1, 0, 0, 0, "t5_start");
    idle(3);
    do_reset();
    cycle(0, 0, 1, 0, "t6_sethh");
    cycle(0, 0, 1, 0, "t6_setmm");
    chk("t6_enter_visible", 108'(blank_o), 108'd0);
`ifdef TIMER_BLINK_EN
    idle(1);
    chk("t6_blank_on", 108'(blank_o), 108'b001100);
    idle(1);
    chk("t6_blank_off", 108'(blank_o), 108'd0);
    idle(1);
    cycle(0, 0, 0, 1, "t6_inc");
    chk("t6_inc_visible", 108'(blank_o), 108'd0);
`else
    idle(3);
    chk("t6_never_blank", 108'(blank_o), 108'd0);
`endif
    cycle(0, 1, 0, 0, "t6_clear");
    for (int i = 0; i < 3000; i++) begin
      if (i % 1000 == 999) do_reset();
      else cycle($urandom_range(0, 11) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, "rand");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
